mux_rr_sel_arbiter: RTL and testbench



---
 rtl/mux_pkg.sv | 12 +
 rtl/mux_rr_pick.sv | 31 +++
 rtl/mux_rr_sel_arbiter.sv | 88 ++++++++
 tb/tb_mux_rr_sel_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the 4-input mux tree front end.
// The 2-bit select drives the tree directly: bit 0 -> s1, bit 1 -> s2.
package mux_pkg;

  localparam int NUM_REQ    = 4;
  localparam int SEL_W      = 2;
  localparam int SEL_S1_BIT = 0;
  localparam int SEL_S2_BIT = 1;

  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/mux_rr_pick.sv
// Combinational rotate-priority picker. Scans from last+1 upward (mod 4)
// and returns the first valid requester as a one-hot grant plus its index.
module mux_rr_pick
  import mux_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
  input  sel_t               last,
  output logic [NUM_REQ-1:0] grant,
  output sel_t               idx,
  output logic               any
);

  sel_t cand;

  // First valid requester after the last winner; index wraps in SEL_W bits.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last + k[SEL_W-1:0];
      if (!any && valid[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/mux_rr_sel_arbiter.sv
// Round-robin arbiter feeding the 4-input mux tree. Registers the winning
// word together with its 2-bit select so data and select reach the tree on
// the same cycle. Output is a single-entry valid/ready slice.
// Optional macro MUX_GRANT_CNT_EN builds saturating per-requester grant
// counters; without it grant_cnt is tied to zero and no counter flops exist.
module mux_rr_sel_arbiter
  import mux_pkg::*;
#(
  parameter int DATA_W  = 1,
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        in_valid,
  input  logic [NUM_REQ*DATA_W-1:0] in_data,
  output logic [NUM_REQ-1:0]        in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output sel_t                      out_sel,
  output logic [NUM_REQ*CNT_W-1:0]  grant_cnt
);

  // The select encoding is exactly two bits wide, so only four requesters fit.
  if (NUM_REQ != mux_pkg::NUM_REQ) begin : g_bad_num_req
    $error("mux_rr_sel_arbiter: NUM_REQ must be 4");
  end

  logic [NUM_REQ-1:0] pick_grant;
  sel_t               pick_idx;
  logic               pick_any;
  sel_t               last;
  logic               slot_free;
  logic               xfer;

  mux_rr_pick u_pick (
    .valid (in_valid),
    .last  (last),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Slot accepts a new word when empty or being drained this cycle.
  always_comb begin
    slot_free = !out_valid || out_ready;
    in_ready  = slot_free ? pick_grant : '0;
    xfer      = pick_any && slot_free;
  end

  // Output register slice and round-robin pointer; reset leaves requester 0 first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      last      <= sel_t'(NUM_REQ - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(pick_idx)*DATA_W +: DATA_W];
      out_sel   <= pick_idx;
      last      <= pick_idx;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_GRANT_CNT_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt;

    // Saturating count of accepted transfers from requester i.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (in_valid[i] && in_ready[i] && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign grant_cnt[i*CNT_W +: CNT_W] = cnt;
  end
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_mux_rr_sel_arbiter.sv
// Directed bench for mux_rr_sel_arbiter (DATA_W=4, CNT_W=2) with a
// scoreboard of expected {sel,data} words and a small round-robin model.
module tb_mux_rr_sel_arbiter;

  localparam int DW = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    in_valid;
  logic [4*DW-1:0] in_data;
  logic [3:0]    in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_sel;
  logic [4*CW-1:0] grant_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  logic [5:0]    sb_q[$];
  logic          m_valid;
  logic [1:0]    m_sel;
  logic [DW-1:0] m_data;
  int            m_last;
  int            m_cnt[4];

  mux_rr_sel_arbiter #(.DATA_W(DW), .NUM_REQ(4), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .grant_cnt (grant_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_win(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (v[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    sb_q.delete();
    m_valid = 1'b0;
    m_sel   = 2'd0;
    m_data  = '0;
    m_last  = 3;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  task automatic chk_cnts(input string tag);
    for (int i = 0; i < 4; i++)
      chk(tag, 32'(grant_cnt[i*CW +: CW]), 32'(m_cnt[i]));
  endtask

  // One cycle starting at a negedge: drive, check, update model, advance.
  task automatic cyc(input logic [3:0] v, input logic ordy);
    int w;
    logic sf;
    logic [3:0] exp_rdy;
    logic [5:0] head;
    in_valid  = v;
    out_ready = ordy;
    #1;
    w  = rr_win(v, m_last);
    sf = !m_valid || ordy;
    exp_rdy = 4'b0000;
    if (w >= 0 && sf) exp_rdy[w] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_sel_hold", 32'(out_sel), 32'(m_sel));
    chk("out_data_hold", 32'(out_data), 32'(m_data));
    chk_cnts("grant_cnt");
    if (m_valid && ordy) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
        head = sb_q.pop_front();
        chk("sb_sel", 32'(out_sel), 32'(head[5:4]));
        chk("sb_data", 32'(out_data), 32'(head[3:0]));
      end
    end
    if (w >= 0 && sf) begin
      m_sel   = 2'(w);
      m_data  = in_data[w*DW +: DW];
      m_valid = 1'b1;
      m_last  = w;
      sb_q.push_back({m_sel, m_data});
`ifdef MUX_GRANT_CNT_EN
      if (m_cnt[w] < (1 << CW) - 1) m_cnt[w]++;
`endif
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    in_data   = 16'hDCBA;
    model_reset();
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_grant_cnt", 32'(grant_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // idle
    repeat (10) cyc(4'b0000, 1'b1);

    // all valid, full throughput: 0,1,2,3,0
    repeat (5) cyc(4'b1111, 1'b1);
    chk("fair_last_sel", 32'(out_sel), 32'd0);
    chk("fair_last_data", 32'(out_data), 32'hA);

    // backpressure: word held, no grants, pointer frozen
    repeat (5) cyc(4'b1111, 1'b0);
    chk("bp_sel", 32'(out_sel), 32'd0);
    cyc(4'b1111, 1'b1);
    chk("bp_resume_sel", 32'(out_sel), 32'd1);
    cyc(4'b0000, 1'b1);

    // move pointer to 3, then sparse request on 2
    cyc(4'b1000, 1'b1);
    cyc(4'b0000, 1'b1);
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    #1;
    chk("sparse_rdy", 32'(in_ready), 32'b0100);
    cyc(4'b0100, 1'b1);
    chk("sparse_sel", 32'(out_sel), 32'b10);
    chk("sparse_data", 32'(out_data), 32'hC);
    cyc(4'b0000, 1'b1);

    // mixed traffic
    for (int n = 0; n < 40; n++) begin
      in_data = 16'($urandom);
      cyc(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    in_data = 16'hDCBA;
    repeat (2) cyc(4'b0000, 1'b1);

    // async reset during a stall
    cyc(4'b1111, 1'b0);
    chk("stall_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_sel", 32'(out_sel), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_grant_cnt", 32'(grant_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    chk("arst_first_rdy", 32'(in_ready), 32'b0001);
    cyc(4'b1111, 1'b1);
    cyc(4'b0000, 1'b1);

    // five transfers from requester 1 (saturates a 2-bit counter)
    repeat (5) cyc(4'b0010, 1'b1);
    cyc(4'b0000, 1'b1);
    chk_cnts("cnt_final");
`ifdef MUX_GRANT_CNT_EN
    chk("cnt1_sat", 32'(grant_cnt[CW +: CW]), 32'd3);
`else
    chk("cnt_off", 32'(grant_cnt), 32'd0);
`endif
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
